// File: rtl/fp_out_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : fp_out_quantizer
// Purpose  : Converts IEEE-754 single-precision filter samples into signed
//            OUT_W-bit fixed point (value x 2^FRAC_W). The data path is a
//            three-stage pipeline (classify, align, round/saturate) that
//            feeds a small output FIFO with a valid/ready handshake.
//            Round to nearest with ties away from zero; results outside the
//            output range saturate. Sticky flags report saturation/NaN and
//            samples dropped because the FIFO was full.
// Ports    : clk        - single clock, rising edge
//            areset     - asynchronous active-high reset
//            i_sample   - 32-bit float sample
//            i_strobe   - capture i_sample this cycle
//            o_data     - quantized sample at the FIFO head (0 when empty)
//            o_valid    - o_data holds a valid sample
//            i_ready    - downstream takes o_data this cycle
//            o_sat      - sticky: saturation or NaN seen
//            o_overrun  - sticky: sample dropped on a full FIFO
//            i_flag_clr - clears both sticky flags (a set event wins)
// Revision : 1.0 - initial release
// ============================================================================
module fp_out_quantizer #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 15,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [31:0]      i_sample,
  input  logic             i_strobe,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sat,
  output logic             o_overrun,
  input  logic             i_flag_clr
);

  // Aligned magnitude carries one extra fractional bit (the rounding bit)
  // and one headroom bit above the largest legal rounded magnitude.
  localparam int c_MW       = OUT_W + 2;
  localparam int c_AW       = $clog2(DEPTH);
  // Left-shift amount of the 24-bit mantissa, including the rounding bit:
  // L = exp - 127 + FRAC_W - 23 + 1 = exp - c_LSH_BIAS.
  localparam int c_LSH_BIAS = 127 - FRAC_W + 23 - 1;
  // With the hidden bit at position 23, L >= c_MW-23 puts a set bit at or
  // above bit c_MW, which is beyond any representable result.
  localparam int c_OVF_L    = c_MW - 23;

  localparam logic [c_MW-1:0]  c_POS_MAX  = c_MW'((1 << (OUT_W - 1)) - 1);
  localparam logic [c_MW-1:0]  c_NEG_MAG  = c_MW'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] c_OUT_POS  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] c_OUT_NEG  = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [c_AW:0]    c_CNT_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // zero or denormal
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // --------------------------------------------------------------------------
  // S1: capture and classify
  // --------------------------------------------------------------------------
  cls_t        w_cls;
  logic        s1_valid_q;
  logic        s1_sign_q;
  cls_t        s1_cls_q;
  logic [7:0]  s1_exp_q;
  logic [23:0] s1_man_q;

  always_comb begin
    w_cls = CLS_NORM;
    if (i_sample[30:23] == 8'h00) begin
      w_cls = CLS_ZERO;
    end else if (i_sample[30:23] == 8'hFF) begin
      w_cls = (i_sample[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_exp_q   <= 8'd0;
      s1_man_q   <= 24'd0;
    end else begin
      s1_valid_q <= i_strobe;
      if (i_strobe) begin
        s1_sign_q <= i_sample[31];
        s1_cls_q  <= w_cls;
        s1_exp_q  <= i_sample[30:23];
        s1_man_q  <= {1'b1, i_sample[22:0]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: align mantissa
  // --------------------------------------------------------------------------
  logic signed [31:0] w_lsh;
  logic signed [31:0] w_rsh;
  logic [47:0]        w_wide;
  logic               w_ovf;

  assign w_lsh = $signed({24'd0, s1_exp_q}) - c_LSH_BIAS;
  assign w_rsh = -w_lsh;

  always_comb begin
    w_wide = 48'd0;
    w_ovf  = 1'b0;
    case (s1_cls_q)
      CLS_NORM: begin
        if (w_lsh >= c_OVF_L) begin
          w_ovf = 1'b1;
        end else if (w_lsh >= 0) begin
          w_wide = {24'd0, s1_man_q} << w_lsh[5:0];
        end else if (w_rsh < 48) begin
          // Larger right shifts leave w_wide at zero rather than wrapping.
          w_wide = {24'd0, s1_man_q} >> w_rsh[5:0];
        end
      end
      CLS_INF: w_ovf = 1'b1;
      default: ;
    endcase
  end

  logic            s2_valid_q;
  logic            s2_sign_q;
  logic            s2_nan_q;
  logic            s2_ovf_q;
  logic [c_MW-1:0] s2_mag_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_mag_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_nan_q  <= (s1_cls_q == CLS_NAN);
        // Upper bits are zero whenever w_ovf is clear; folding them in keeps
        // the overflow decision self-contained.
        s2_ovf_q  <= w_ovf | (|w_wide[47:c_MW]);
        s2_mag_q  <= w_wide[c_MW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3: round, saturate, apply sign
  // --------------------------------------------------------------------------
  logic [c_MW:0]      w_mag_p1;
  logic [c_MW-1:0]    w_round;
  logic [OUT_W-1:0]   w_res;
  logic               w_sat;

  // Adding half an LSB to the magnitude and truncating gives ties away from
  // zero once the sign is applied afterwards.
  assign w_mag_p1 = {1'b0, s2_mag_q} + (c_MW + 1)'(1);
  assign w_round  = c_MW'(w_mag_p1 >> 1);

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    if (s2_nan_q) begin
      w_sat = 1'b1;
    end else if (!s2_sign_q) begin
      if (s2_ovf_q || (w_round > c_POS_MAX)) begin
        w_res = c_OUT_POS;
        w_sat = 1'b1;
      end else begin
        w_res = w_round[OUT_W-1:0];
      end
    end else begin
      if (s2_ovf_q || (w_round > c_NEG_MAG)) begin
        w_res = c_OUT_NEG;
        w_sat = 1'b1;
      end else begin
        // A zero magnitude negates to zero, so no negative zero appears.
        w_res = -w_round[OUT_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO and sticky flags
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wr_ptr_q;
  logic [c_AW-1:0]  rd_ptr_q;
  logic [c_AW:0]    count_q;
  logic [c_AW:0]    count_d;
  logic             sat_q;
  logic             sat_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign o_valid = (count_q != '0);
  assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign w_full  = (count_q == c_CNT_FULL);
  assign w_pop   = o_valid & i_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push  = s2_valid_q & (~w_full | w_pop);
  assign w_drop  = s2_valid_q & w_full & ~w_pop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (c_AW + 1)'(1);
      2'b01:   count_d = count_q - (c_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    sat_d     = (s2_valid_q & w_sat) | (sat_q & ~i_flag_clr);
    overrun_d = w_drop | (overrun_q & ~i_flag_clr);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_res;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
      count_q   <= count_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_sat     = sat_q;
  assign o_overrun = overrun_q;

endmodule
`default_nettype wire

// File: doc/fp_out_quantizer.md
FP_OUT_QUANTIZER -- requirements
Module: fp_out_quantizer

Interface
REQ-001 Parameter: OUT_W, 16, output integer width in bits (legal 8..24).
REQ-002 Parameter: FRAC_W, 15, output fractional bits; output = float x 2^FRAC_W (legal 0..OUT_W-1).
REQ-003 Parameter: DEPTH, 4, output FIFO depth (power of 2, >= 2).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: areset  in  1  reset, asynchronous, active-high.
REQ-006 Port: i_sample  in  32  IEEE-754 single-precision filter output sample.
REQ-007 Port: i_strobe  in  1  sample-rate pulse; i_sample captured on cycles where i_strobe=1.
REQ-008 Port: o_data  out  OUT_W  signed two's-complement quantized sample (FIFO head).
REQ-009 Port: o_valid  out  1  o_data holds a valid sample.
REQ-010 Port: i_ready  in  1  downstream accepts o_data this cycle.
REQ-011 Port: o_sat  out  1  sticky: a sample was saturated or was NaN.
REQ-012 Port: o_overrun  out  1  sticky: a sample was dropped because the FIFO was full.
REQ-013 Port: i_flag_clr  in  1  clears o_sat and o_overrun.

Function
REQ-014 Three-stage pipeline: S1 captures and classifies (zero/denormal, normal, inf, NaN); S2 aligns mantissa by shift = exp-127+FRAC_W-23; S3 rounds, saturates, and writes to FIFO.
REQ-015 Latency: i_strobe at cycle N, FIFO empty -> o_valid=1 with result at cycle N+3.
REQ-016 Throughput: one sample per cycle; back-to-back strobes are accepted without stall.
REQ-017 Rounding: round to nearest, ties away from zero, applied to magnitude before sign.
REQ-018 Saturation: result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; a clamped result sets o_sat.
REQ-019 -2^(OUT_W-1) exactly representable: no saturation, o_sat unchanged.
REQ-020 Zero, negative zero, and denormals -> 0, o_sat unchanged.
REQ-021 +Inf -> max positive, -Inf -> max negative; both set o_sat.
REQ-022 NaN -> 0; sets o_sat.
REQ-023 Values whose rounded magnitude is 0 -> 0, including negative inputs (no negative zero).
REQ-024 Right shifts beyond 25 bits produce magnitude 0 before rounding; no wrap of the shift amount.
REQ-025 Handshake: pop when o_valid && i_ready; o_data/o_valid hold stable while o_valid && !i_ready.
REQ-026 FIFO full and S3 write with no pop in the same cycle -> sample dropped, FIFO unchanged, o_overrun set.
REQ-027 FIFO full, S3 write and pop in the same cycle -> write accepted, occupancy unchanged.
REQ-028 FIFO empty and S3 write in the same cycle -> no fall-through; o_valid rises next cycle, per REQ-015.
REQ-029 Pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-030 Sticky flags: a set event and i_flag_clr in the same cycle -> flag ends at 1 (set wins).
REQ-031 i_strobe while areset=1 is ignored.

Reset
REQ-032 areset=1 asynchronously forces o_data=0, o_valid=0, o_sat=0, o_overrun=0, FIFO empty, and all pipeline valid bits to 0.
REQ-033 Samples in flight when reset asserts are discarded; none appear after reset release.
REQ-034 First i_strobe in the cycle after areset deasserts is processed normally (output at +3).

Verification (OUT_W=16, FRAC_W=15, DEPTH=4)
REQ-035 Scenario: strobes with 0x3F000000, 0xBE800000, 0xBF800000 and i_ready=1 -> o_data 0x4000, 0xE000, 0x8000 at N+3, N+4, N+5; o_sat stays 0.
REQ-036 Scenario: strobes with 0x3F800000 (1.0) and 0x7F800000 (+Inf) -> o_data 0x7FFF both, o_sat=1; then i_flag_clr -> o_sat=0.
REQ-037 Scenario: strobes with 0x37800000 (2^-16, exactly half LSB) and 0xB7800000 -> o_data 0x0001 and 0xFFFF; strobe with 0x37000000 -> 0x0000.
REQ-038 Scenario: i_ready=0, five consecutive strobes -> four samples held, fifth dropped, o_overrun=1; then i_ready=1 -> first four drained in order, o_valid drops after the fourth.
REQ-039 Scenario: strobe at N with i_ready=0, areset pulsed at N+2 -> o_valid never asserts for that sample; all outputs 0 after reset.
REQ-040 Scenario: NaN 0x7FC00000 with i_flag_clr=1 in the same cycle the flag sets -> o_data 0x0000 and o_sat=1.
